// File: rtl/updown_mod_counter.sv
// rtl/updown_mod_counter.sv - parametrised up/down modulo counter with wrap/saturate and status flags
module updown_mod_counter #(
  parameter int     WIDTH     = 4,
  parameter longint MODULUS   = 16,
  parameter int     SATURATE  = 0,
  parameter int     RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             carry,
  output logic             ovf
);

  localparam int               W1    = WIDTH + 1;
  localparam logic [W1-1:0]    MAX_C = W1'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0] MAX_W = MAX_C[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST_W = WIDTH'(RESET_VAL);

  logic [W1-1:0] cnt_ext;
  logic [W1-1:0] din_ext;
  logic          at_max;
  logic          at_zero;
  logic          din_ok;

  // One extra bit keeps MODULUS = 2^WIDTH representable in the compares.
  assign cnt_ext = {1'b0, count};
  assign din_ext = {1'b0, din};
  assign at_max  = (cnt_ext == MAX_C);
  assign at_zero = (count == '0);
  assign din_ok  = (din_ext <= MAX_C);

  assign tc = en & ((up & at_max) | (~up & at_zero));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= RST_W;
      carry <= 1'b0;
      ovf   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      carry <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      carry <= 1'b0;
      if (din_ok) begin
        count <= din;
      end else begin
        count <= MAX_W;
        ovf   <= 1'b1;
      end
    end else if (en) begin
      if (up) begin
        if (at_max) begin
          carry <= 1'b1;
          ovf   <= 1'b1;
          count <= (SATURATE != 0) ? count : '0;
        end else begin
          carry <= 1'b0;
          count <= count + WIDTH'(1);
        end
      end else begin
        if (at_zero) begin
          carry <= 1'b1;
          ovf   <= 1'b1;
          count <= (SATURATE != 0) ? count : MAX_W;
        end else begin
          carry <= 1'b0;
          count <= count - WIDTH'(1);
        end
      end
    end else begin
      carry <= 1'b0;
    end
  end

endmodule
